// File: rtl/joy_serial_if.sv
// joy_serial_if: pin bundle for the external 74HC165-style joystick chain.
//   joyD  - serial data from the chain (chain -> scanner)
//   joyLd - parallel-load strobe, active-low (scanner -> chain)
//   joyCk - shift clock, chain shifts on its rising edge (scanner -> chain)
// Modports: master = the scanner (joy_serial), slave = the chain.
interface joy_serial_if;
  logic joyD;
  logic joyLd;
  logic joyCk;

  modport master (
    input  joyD,
    output joyLd,
    output joyCk
  );

  modport slave (
    output joyD,
    input  joyLd,
    input  joyCk
  );
endinterface

// File: rtl/joy_serial.sv
// joy_serial: serial joystick front end for the ZX2/ZXD boards.
// Continuously scans a 2*NB-bit shift-register chain holding two pads and
// presents them as negative-logic words plus an active-high Kempston byte.
//
// Ports:
//   clock - system clock
//   reset - asynchronous active-low reset
//   ce    - clock enable (7 MHz enable from the top level)
//   chain - chain pins (joyD in, joyLd/joyCk out), master side
//   joy1  - pad 1, negative logic (0 = pressed)
//   joy2  - pad 2, negative logic
//   kemp  - Kempston byte {2'b00, F2, F1, U, D, L, R}, active-high
//   upd   - one-clock pulse whenever joy1/joy2/kemp are rewritten
//
// Optional feature: define JOY_DEBOUNCE_EN to commit only when two consecutive
// frames read identically.
module joy_serial #(
  parameter int unsigned DIV = 8,  // ce pulses per scan tick, 2..255
  parameter int unsigned NB  = 12  // buttons per pad
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ce,
  joy_serial_if.master       chain,
  output logic [NB-1:0]      joy1,
  output logic [NB-1:0]      joy2,
  output logic [7:0]         kemp,
  output logic               upd
);

  localparam int unsigned RW = 2 * NB;
  localparam int unsigned IW = $clog2(RW);
  localparam logic [7:0]    DivLast = 8'(DIV - 1);
  localparam logic [IW-1:0] IdxLast = IW'(RW - 1);

  typedef enum logic [1:0] {StLoad, StSample, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      div_q, div_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   raw_q, raw_d;
  logic            ld_q, ld_d;
  logic            ck_q, ck_d;
  logic [NB-1:0]   joy1_q, joy1_d;
  logic [NB-1:0]   joy2_q, joy2_d;
  logic [7:0]      kemp_q, kemp_d;
  logic            upd_q, upd_d;
  logic            tick;
  logic            do_commit;
`ifdef JOY_DEBOUNCE_EN
  logic [RW-1:0]   prev_q, prev_d;
`endif

  // Tick divider: one tick every DIV ce pulses.
  always_comb begin
    tick  = ce && (div_q == DivLast);
    div_d = div_q;
    if (ce) begin
      div_d = (div_q == DivLast) ? 8'd0 : div_q + 8'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    raw_d     = raw_q;
    ld_d      = ld_q;
    ck_d      = ck_q;
    joy1_d    = joy1_q;
    joy2_d    = joy2_q;
    kemp_d    = kemp_q;
    upd_d     = 1'b0;
    do_commit = 1'b0;
`ifdef JOY_DEBOUNCE_EN
    prev_d    = prev_q;
`endif
    if (tick) begin
      unique case (state_q)
        StLoad: begin
          ld_d    = 1'b0;
          ck_d    = 1'b1;
          idx_d   = '0;
          state_d = StSample;
        end
        StSample: begin
          // Data has had a full tick to settle since load or the last shift.
          ld_d         = 1'b1;
          ck_d         = 1'b0;
          raw_d[idx_q] = chain.joyD;
          state_d      = StShift;
        end
        StShift: begin
          ck_d = 1'b1;
          if (idx_q == IdxLast) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = StSample;
          end
        end
        StDone: begin
          ck_d    = 1'b1;
          ld_d    = 1'b1;
          state_d = StLoad;
`ifdef JOY_DEBOUNCE_EN
          // Commit only a frame that matches the one before it.
          prev_d    = raw_q;
          do_commit = (raw_q == prev_q);
`else
          do_commit = 1'b1;
`endif
        end
        default: state_d = StLoad;
      endcase
    end

    if (do_commit) begin
      joy1_d = raw_q[NB-1:0];
      joy2_d = raw_q[RW-1:NB];
      kemp_d = {2'b00, ~raw_q[5], ~raw_q[4], ~raw_q[0], ~raw_q[1], ~raw_q[2], ~raw_q[3]};
      upd_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StLoad;
      div_q   <= '0;
      idx_q   <= '0;
      raw_q   <= '1;
      ld_q    <= 1'b1;
      ck_q    <= 1'b1;
      joy1_q  <= '1;
      joy2_q  <= '1;
      kemp_q  <= 8'h00;
      upd_q   <= 1'b0;
`ifdef JOY_DEBOUNCE_EN
      prev_q  <= '1;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      raw_q   <= raw_d;
      ld_q    <= ld_d;
      ck_q    <= ck_d;
      joy1_q  <= joy1_d;
      joy2_q  <= joy2_d;
      kemp_q  <= kemp_d;
      upd_q   <= upd_d;
`ifdef JOY_DEBOUNCE_EN
      prev_q  <= prev_d;
`endif
    end
  end

  assign chain.joyLd = ld_q;
  assign chain.joyCk = ck_q;
  assign joy1        = joy1_q;
  assign joy2        = joy2_q;
  assign kemp        = kemp_q;
  assign upd         = upd_q;

endmodule

// File: tb/tb_joy_serial.sv
// tb_joy_serial: bench for joy_serial with a behavioural 74HC165 chain model and
// a frame-level reference model of what the outputs should show.
module tb_joy_serial;
  localparam int unsigned DIV = 2;
  localparam int unsigned NB  = 12;
  localparam int unsigned FrameClocks = (4 * NB + 2) * DIV;

  logic          clock = 1'b0;
  logic          reset;
  logic          ce;
  logic [NB-1:0] joy1;
  logic [NB-1:0] joy2;
  logic [7:0]    kemp;
  logic          upd;

  joy_serial_if chain_if ();

  joy_serial #(
    .DIV (DIV),
    .NB  (NB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .chain (chain_if.master),
    .joy1  (joy1),
    .joy2  (joy2),
    .kemp  (kemp),
    .upd   (upd)
  );

  always #5 clock = ~clock;

  // Chain model: pads loaded while joyLd falls, shifted out LSB first on joyCk rise.
  logic [NB-1:0]   pad1;
  logic [NB-1:0]   pad2;
  logic [2*NB-1:0] sr;

  always @(posedge chain_if.joyCk or negedge chain_if.joyLd) begin
    if (!chain_if.joyLd) sr <= {pad2, pad1};
    else                 sr <= {1'b1, sr[2*NB-1:1]};
  end
  assign chain_if.joyD = sr[0];

  int upd_cnt = 0;
  always @(negedge clock) if (upd === 1'b1) upd_cnt = upd_cnt + 1;

  int errors = 0;
  int checks = 0;

  // Reference model state: what a complete scan frame should leave behind.
  logic [2*NB-1:0] frame_data;
  logic            frame_active;
  logic [2*NB-1:0] m_prev;
  logic [NB-1:0]   m_joy1;
  logic [NB-1:0]   m_joy2;
  logic [7:0]      m_kemp;
  int              m_upd;

  function automatic logic [7:0] kemp_of(input logic [NB-1:0] p);
    logic [7:0] k;
    k    = 8'h00;
    k[0] = !p[3];  // right
    k[1] = !p[2];  // left
    k[2] = !p[1];  // down
    k[3] = !p[0];  // up
    k[4] = !p[4];  // fire 1 = B
    k[5] = !p[5];  // fire 2 = C
    return k;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_joy1       = '1;
    m_joy2       = '1;
    m_kemp       = 8'h00;
    m_prev       = '1;
    frame_active = 1'b0;
  endtask

  task automatic model_frame_end();
    logic commit;
`ifdef JOY_DEBOUNCE_EN
    commit = (frame_data == m_prev);
    m_prev = frame_data;
`else
    commit = 1'b1;
`endif
    if (commit) begin
      m_joy1 = frame_data[NB-1:0];
      m_joy2 = frame_data[2*NB-1:NB];
      m_kemp = kemp_of(m_joy1);
      m_upd++;
    end
  endtask

  task automatic frame_start();
    if (frame_active) model_frame_end();
    frame_data   = {pad2, pad1};
    frame_active = 1'b1;
  endtask

  // Wait (bounded) for the next falling joyLd, i.e. the start of a frame.
  task automatic wait_ld_fall(output int n);
    logic prev_ld;
    logic found;
    found   = 1'b0;
    n       = 0;
    prev_ld = chain_if.joyLd;
    while (n < 4 * FrameClocks && !found) begin
      @(negedge clock);
      n++;
      if (prev_ld === 1'b1 && chain_if.joyLd === 1'b0) found = 1'b1;
      prev_ld = chain_if.joyLd;
    end
    check("ld_fall_seen", 32'(found), 32'd1);
    if (found) frame_start();
  endtask

  task automatic check_model(input string tag);
    #1;
    check({tag, "_joy1"}, 32'(joy1), 32'(m_joy1));
    check({tag, "_joy2"}, 32'(joy2), 32'(m_joy2));
    check({tag, "_kemp"}, 32'(kemp), 32'(m_kemp));
    check({tag, "_upd"},  32'(upd_cnt), 32'(m_upd));
  endtask

  task automatic next_frame(input string tag);
    int n;
    wait_ld_fall(n);
    check_model(tag);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    ce    = 1'b1;
    pad1  = '1;
    pad2  = '1;
    m_upd = 0;
    model_reset();

    // Reset values.
    repeat (3) @(negedge clock);
    #1;
    check("rst_ld",   32'(chain_if.joyLd), 32'd1);
    check("rst_ck",   32'(chain_if.joyCk), 32'd1);
    check("rst_joy1", 32'(joy1), 32'hFFF);
    check("rst_joy2", 32'(joy2), 32'hFFF);
    check("rst_kemp", 32'(kemp), 32'h00);
    check("rst_upd",  32'(upd),  32'd0);

    // First LOAD comes DIV ce pulses after release; joyLd low for DIV clocks.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("first_ld_wait", 32'(chain_if.joyLd), 32'd1);
    @(negedge clock);
    check("first_ld_low", 32'(chain_if.joyLd), 32'd0);
    frame_start();
    @(negedge clock);
    check("ld_low_2", 32'(chain_if.joyLd), 32'd0);
    @(negedge clock);
    check("ld_high_after", 32'(chain_if.joyLd), 32'd1);
    wait_ld_fall(n);
    check("frame_period", 32'(n + 2), 32'(FrameClocks));
    check_model("idle0");
    next_frame("idle1");
    next_frame("idle2");

    // U + A on pad 1.
    pad1 = 12'hFBE;
    repeat (3) next_frame("ua");
    check("ua_joy1", 32'(joy1), 32'hFBE);
    check("ua_kemp", 32'(kemp), 32'h08);

    // R + B + C on pad 1, then X on pad 2.
    pad1 = 12'hFC7;
    repeat (3) next_frame("rbc");
    check("rbc_kemp", 32'(kemp), 32'h31);
    pad2 = 12'hBFF;
    repeat (3) next_frame("x2");
    check("x2_joy2", 32'(joy2), 32'hBFF);
    check("x2_joy1", 32'(joy1), 32'hFC7);
    check("x2_kemp", 32'(kemp), 32'h31);

    // Random pads.
    for (int i = 0; i < 6; i++) begin
      pad1 = NB'($urandom);
      pad2 = NB'($urandom);
      repeat (3) next_frame("rnd");
    end

    // Reset mid-frame during a SHIFT tick, pad 1 Down pressed.
    pad1 = 12'hFFD;
    pad2 = 12'hFFF;
    n = 0;
    while (n < 30 || chain_if.joyCk !== 1'b1) begin
      @(negedge clock);
      n++;
    end
    reset = 1'b0;
    #1;
    model_reset();
    check("mid_rst_joy1", 32'(joy1), 32'hFFF);
    check("mid_rst_joy2", 32'(joy2), 32'hFFF);
    check("mid_rst_kemp", 32'(kemp), 32'h00);
    check("mid_rst_upd",  32'(upd),  32'd0);
    check("mid_rst_ld",   32'(chain_if.joyLd), 32'd1);
    repeat (3) @(negedge clock);
    check("mid_rst_updcnt", 32'(upd_cnt), 32'(m_upd));
    reset = 1'b1;
    repeat (3) next_frame("post_rst");
    check("post_rst_joy1", 32'(joy1), 32'hFFD);
    check("post_rst_kemp", 32'(kemp), 32'h04);

    // ce held low mid-frame; captured on a SAMPLE tick so joyCk is known low.
    pad1 = 12'hF7F;
    next_frame("pre_ce");
    repeat (2) @(negedge clock);
    ce = 1'b0;
    repeat (500) @(negedge clock);
    #1;
    check("ce_hold_ld_mid", 32'(chain_if.joyLd), 32'd1);
    check("ce_hold_ck_mid", 32'(chain_if.joyCk), 32'd0);
    repeat (500) @(negedge clock);
    #1;
    check("ce_hold_ld", 32'(chain_if.joyLd), 32'd1);
    check("ce_hold_ck", 32'(chain_if.joyCk), 32'd0);
    check("ce_hold_joy1", 32'(joy1), 32'(m_joy1));
    check("ce_hold_upd", 32'(upd_cnt), 32'(m_upd));
    ce = 1'b1;
    repeat (3) next_frame("ce_resume");

    // Alternate pad 1 every frame.
    for (int i = 0; i < 6; i++) begin
      pad1 = (i % 2 == 0) ? 12'hFFE : 12'hFFB;
      next_frame("alt");
    end
    next_frame("alt_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
